rs_syndrome_param: RTL and testbench

// - Parametrised RS syndrome calculator for the DVB-T RS decoder front end. Generalises the fixed 16-output syndrom block.
// - Accepts a byte stream of received codeword symbols with valid/start-of-packet qualifiers.
// - Computes NSYM syndromes over GF(2^8) by Horner accumulation.
// - Presents them as one packed bus with a completion pulse and an error-free flag, for the key-equation solver.

---
 rtl/rs_syndrome_param.sv | 146 ++++++++++++++
 tb/tb_rs_syndrome_param.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_syndrome_param.sv
// Reed-Solomon syndrome calculator over GF(2^8): Horner accumulation of NSYM syndromes
// per codeword, with completion pulse, error-free flag and early-start abort detection.
module rs_syndrome_param #(
    parameter int          N         = 204,
    parameter int          NSYM      = 16,
    parameter int          FCR       = 0,
    parameter logic [8:0]  PRIM_POLY = 9'h11D
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                In_Valid,
    input  logic                In_Sop,
    input  logic [7:0]          Msg_Rsv,
    output logic [NSYM*8-1:0]   Synd_Out,
    output logic                Synd_Valid,
    output logic                Err_Free,
    output logic                Frame_Err,
    output logic                Busy
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    typedef logic [NSYM-1:0][7:0] synd_vec_t;

    // Multiply by x modulo the field polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return a[7] ? ({a[6:0], 1'b0} ^ PRIM_POLY[7:0]) : {a[6:0], 1'b0};
    endfunction

    // With b fixed at elaboration this reduces to a pure XOR network.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] prod;
        logic [7:0] shifted;
        prod    = '0;
        shifted = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) prod = prod ^ shifted;
            shifted = xtime(shifted);
        end
        return prod;
    endfunction

    function automatic logic [7:0] alpha_pow(input int e);
        logic [7:0] p;
        p = 8'h01;
        for (int i = 0; i < 255; i++) begin
            if (i < (e % 255)) p = xtime(p);
        end
        return p;
    endfunction

    state_t         state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    synd_vec_t      acc_q, acc_d;
    synd_vec_t      synd_q, synd_d;
    logic           synd_valid_q, synd_valid_d;
    logic           err_free_q, err_free_d;
    logic           frame_err_q, frame_err_d;

    synd_vec_t      horner;
    logic           last_sym;

    for (genvar j = 0; j < NSYM; j++) begin : g_root
        localparam logic [7:0] ROOT = alpha_pow(FCR + j);
        assign horner[j] = gf_mul(acc_q[j], ROOT) ^ Msg_Rsv;
    end

    assign last_sym = (count_q == CW'(N - 1));

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        count_d      = count_q;
        acc_d        = acc_q;
        synd_d       = synd_q;
        err_free_d   = err_free_q;
        synd_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        if (In_Valid) begin
            unique case (state_q)
                IDLE: begin
                    // Symbols outside a frame are silently dropped.
                    if (In_Sop) begin
                        acc_d   = {NSYM{Msg_Rsv}};
                        count_d = CW'(1);
                        state_d = ACC;
                    end
                end
                ACC: begin
                    if (In_Sop) begin
                        frame_err_d = 1'b1;
                        acc_d       = {NSYM{Msg_Rsv}};
                        count_d     = CW'(1);
                    end else begin
                        acc_d = horner;
                        if (last_sym) begin
                            synd_d       = horner;
                            synd_valid_d = 1'b1;
                            err_free_d   = (horner == '0);
                            count_d      = '0;
                            state_d      = IDLE;
                        end else begin
                            count_d = count_q + CW'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: accumulators and the syndrome register are reset too, since Synd_Out must read zero after reset.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= IDLE;
            count_q      <= '0;
            acc_q        <= '0;
            synd_q       <= '0;
            synd_valid_q <= 1'b0;
            err_free_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            count_q      <= count_d;
            acc_q        <= acc_d;
            synd_q       <= synd_d;
            synd_valid_q <= synd_valid_d;
            err_free_q   <= err_free_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign Synd_Out   = synd_q;
    assign Synd_Valid = synd_valid_q;
    assign Err_Free   = err_free_q;
    assign Frame_Err  = frame_err_q;
    assign Busy       = (state_q == ACC);

endmodule

// File: tb/tb_rs_syndrome_param.sv
// Directed bench for rs_syndrome_param: RS(204,188) codewords built by a reference encoder,
// single-symbol error patterns with closed-form syndromes, gaps, aborts, reset and back-to-back frames.
module tb_rs_syndrome_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic         in_valid_a, in_sop_a;
    logic [7:0]   msg_a;
    logic [127:0] synd_a;
    logic         sv_a, ef_a, fe_a, busy_a;

    logic         in_valid_b, in_sop_b;
    logic [7:0]   msg_b;
    logic [31:0]  synd_b;
    logic         sv_b, ef_b, fe_b, busy_b;

    rs_syndrome_param #(.N(204), .NSYM(16), .FCR(0), .PRIM_POLY(9'h11D)) u_dut_a (
        .Clk(clk), .Reset(rst_n), .In_Valid(in_valid_a), .In_Sop(in_sop_a), .Msg_Rsv(msg_a),
        .Synd_Out(synd_a), .Synd_Valid(sv_a), .Err_Free(ef_a), .Frame_Err(fe_a), .Busy(busy_a)
    );

    rs_syndrome_param #(.N(20), .NSYM(4), .FCR(0), .PRIM_POLY(9'h11D)) u_dut_b (
        .Clk(clk), .Reset(rst_n), .In_Valid(in_valid_b), .In_Sop(in_sop_b), .Msg_Rsv(msg_b),
        .Synd_Out(synd_b), .Synd_Valid(sv_b), .Err_Free(ef_b), .Frame_Err(fe_b), .Busy(busy_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // GF(2^8) via exp/log tables.
    logic [7:0] exp_t [0:254];
    int         log_t [0:255];

    task automatic init_tables();
        logic [7:0] p;
        p = 8'h01;
        for (int i = 0; i < 255; i++) begin
            exp_t[i]  = p;
            log_t[p]  = i;
            p = p[7] ? ({p[6:0], 1'b0} ^ 8'h1D) : {p[6:0], 1'b0};
        end
        log_t[0] = 0;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return exp_t[(log_t[a] + log_t[b]) % 255];
    endfunction

    logic [7:0] cw     [0:254];
    logic [7:0] frm_a  [0:203];
    logic [7:0] frm_b1 [0:19];
    logic [7:0] frm_b2 [0:19];

    // Systematic encoder, generator roots alpha^0 .. alpha^(nsym-1).
    task automatic encode(input int n, input int nsym, input int seed);
        logic [7:0] g [0:32];
        logic [7:0] r [0:31];
        logic [7:0] fbk;
        for (int k = 0; k <= 32; k++) g[k] = 8'h00;
        for (int k = 0; k < 32; k++) r[k] = 8'h00;
        g[0] = 8'h01;
        for (int i = 0; i < nsym; i++) begin
            for (int k = i + 1; k >= 1; k--) g[k] = g[k-1] ^ gmul(g[k], exp_t[i]);
            g[0] = gmul(g[0], exp_t[i]);
        end
        for (int i = 0; i < n - nsym; i++) begin
            cw[i] = 8'(seed * 13 + i * 37 + i * i * 7);
            fbk   = cw[i] ^ r[nsym-1];
            for (int k = nsym - 1; k >= 1; k--) r[k] = r[k-1] ^ gmul(fbk, g[k]);
            r[0] = gmul(fbk, g[0]);
        end
        for (int k = 0; k < nsym; k++) cw[n - nsym + k] = r[nsym - 1 - k];
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int sv_cnt_a = 0, fe_cnt_a = 0, both_cnt = 0, sv_cnt_b = 0;
    int sv_cyc_b [0:1];

    always @(negedge clk) begin
        if (sv_a) sv_cnt_a++;
        if (fe_a) fe_cnt_a++;
        if ((sv_a && fe_a) || (sv_b && fe_b)) both_cnt++;
        if (sv_b) begin
            if (sv_cnt_b < 2) sv_cyc_b[sv_cnt_b] = cyc;
            sv_cnt_b++;
        end
    end

    task automatic step_a(input logic v, input logic sop, input logic [7:0] d);
        in_valid_a = v;
        in_sop_a   = sop;
        msg_a      = d;
        @(negedge clk);
    endtask

    task automatic step_b(input logic v, input logic sop, input logic [7:0] d);
        in_valid_b = v;
        in_sop_b   = sop;
        msg_b      = d;
        @(negedge clk);
    endtask

    // Sends frm_a[start..stop-1] (In_Sop on index 0), optionally with idle gaps and one corrupted symbol.
    task automatic send_a(input string tag, input bit gap, input int start, input int stop,
                          input int err_pos, input logic [7:0] err_val);
        logic [7:0] d;
        for (int i = start; i < stop; i++) begin
            d = frm_a[i] ^ ((i == err_pos) ? err_val : 8'h00);
            if (i == stop - 1) begin
                check({tag, "_busy_pre"}, busy_a, 1'b1);
                check({tag, "_sv_pre"}, sv_a, 1'b0);
            end
            step_a(1'b1, i == 0, d);
            if (gap && i != stop - 1) step_a(1'b0, 1'b0, 8'hA5);
        end
    endtask

    task automatic check_frame_a(input string tag, input logic [127:0] exp_synd, input logic exp_ef);
        check({tag, "_sv"}, sv_a, 1'b1);
        check({tag, "_synd"}, synd_a, exp_synd);
        check({tag, "_ef"}, ef_a, exp_ef);
        check({tag, "_busy"}, busy_a, 1'b0);
        step_a(1'b0, 1'b0, 8'h00);
        check({tag, "_sv_drop"}, sv_a, 1'b0);
        check({tag, "_synd_hold"}, synd_a, exp_synd);
    endtask

    logic [127:0] exp_v;
    logic [127:0] saved_v;
    int           sv_before, fe_before;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        init_tables();
        rst_n = 1'b0;
        in_valid_a = 1'b0; in_sop_a = 1'b0; msg_a = 8'h00;
        in_valid_b = 1'b0; in_sop_b = 1'b0; msg_b = 8'h00;
        repeat (3) @(negedge clk);

        check("rst_synd", synd_a, 128'h0);
        check("rst_sv", sv_a, 1'b0);
        check("rst_ef", ef_a, 1'b0);
        check("rst_fe", fe_a, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_synd_b", synd_b, 32'h0);

        rst_n = 1'b1;
        step_a(1'b0, 1'b0, 8'h00);

        encode(204, 16, 1);
        for (int i = 0; i < 204; i++) frm_a[i] = cw[i];

        // Accepts without In_Sop while idle are dropped.
        repeat (3) step_a(1'b1, 1'b0, 8'h33);
        check("idle_drop_busy", busy_a, 1'b0);

        send_a("clean", 1'b0, 0, 204, -1, 8'h00);
        check_frame_a("clean", 128'h0, 1'b1);

        send_a("last5a", 1'b0, 0, 204, 203, 8'h5A);
        check_frame_a("last5a", {16{8'h5A}}, 1'b0);

        send_a("gap", 1'b1, 0, 204, -1, 8'h00);
        check_frame_a("gap", 128'h0, 1'b1);
        check("sv_count_3", sv_cnt_a, 3);

        // Error e=1 at degree 203: S_j = alpha^(203*j).
        exp_v = '0;
        for (int j = 0; j < 16; j++) exp_v[8*j +: 8] = exp_t[(203 * j) % 255];
        send_a("first01", 1'b0, 0, 204, 0, 8'h01);
        check_frame_a("first01", exp_v, 1'b0);
        saved_v = exp_v;

        // Early In_Sop at symbol 100 aborts the frame and restarts.
        send_a("part", 1'b0, 0, 99, -1, 8'h00);
        step_a(1'b1, 1'b1, frm_a[0]);
        check("early_fe", fe_a, 1'b1);
        check("early_sv", sv_a, 1'b0);
        check("early_busy", busy_a, 1'b1);
        check("early_synd_hold", synd_a, saved_v);
        check("early_ef_hold", ef_a, 1'b0);
        step_a(1'b1, 1'b0, frm_a[1]);
        check("early_fe_drop", fe_a, 1'b0);
        send_a("early", 1'b0, 2, 204, -1, 8'h00);
        check_frame_a("early", 128'h0, 1'b1);
        check("fe_count_1", fe_cnt_a, 1);

        // Reset at symbol 50 discards the partial frame with no pulses.
        send_a("rstmid", 1'b0, 0, 49, -1, 8'h00);
        sv_before = sv_cnt_a;
        fe_before = fe_cnt_a;
        in_valid_a = 1'b1; in_sop_a = 1'b0; msg_a = frm_a[49];
        rst_n = 1'b0;
        #1;
        check("rstmid_synd", synd_a, 128'h0);
        check("rstmid_ef", ef_a, 1'b0);
        check("rstmid_busy", busy_a, 1'b0);
        check("rstmid_sv", sv_a, 1'b0);
        check("rstmid_fe", fe_a, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step_a(1'b0, 1'b0, 8'h00);
        step_a(1'b0, 1'b0, 8'h00);
        check("rstmid_sv_cnt", sv_cnt_a, sv_before);
        check("rstmid_fe_cnt", fe_cnt_a, fe_before);
        check("rstmid_busy_after", busy_a, 1'b0);
        send_a("recover", 1'b0, 0, 204, -1, 8'h00);
        check_frame_a("recover", 128'h0, 1'b1);

        // Small instance: two back-to-back clean RS(20,16) frames.
        encode(20, 4, 7);
        for (int i = 0; i < 20; i++) frm_b1[i] = cw[i];
        encode(20, 4, 9);
        for (int i = 0; i < 20; i++) frm_b2[i] = cw[i];
        for (int i = 0; i < 40; i++) begin
            step_b(1'b1, (i % 20) == 0, (i < 20) ? frm_b1[i] : frm_b2[i - 20]);
            if (i == 19 || i == 39) begin
                check((i == 19) ? "b2b_f1_sv" : "b2b_f2_sv", sv_b, 1'b1);
                check((i == 19) ? "b2b_f1_synd" : "b2b_f2_synd", synd_b, 32'h0);
                check((i == 19) ? "b2b_f1_ef" : "b2b_f2_ef", ef_b, 1'b1);
            end
        end
        step_b(1'b0, 1'b0, 8'h00);
        step_b(1'b0, 1'b0, 8'h00);
        check("b2b_sv_count", sv_cnt_b, 2);
        check("b2b_spacing", sv_cyc_b[1] - sv_cyc_b[0], 20);
        check("b2b_busy", busy_b, 1'b0);

        check("sv_fe_exclusive", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
